// File: rtl/mc_rfr_sched.sv
// Refresh scheduler: counts owed refreshes, takes the command bus from the main FSM,
// then issues one precharge-all and an auto-refresh per chip select needing refresh.
module mc_rfr_sched #(
    parameter int unsigned DEBT_MAX = 7,
    parameter int unsigned URG_LVL  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rfr_req,
    output logic       rfr_ack,
    input  logic [7:0] cs_need_rfr,
    input  logic       mem_busy,
    input  logic [3:0] trp,
    input  logic [3:0] trfc,
    output logic       rfr_busy,
    output logic       rfr_urgent,
    output logic       cmd_pre,
    output logic       cmd_ref,
    output logic [7:0] cmd_cs,
    output logic [2:0] debt,
    output logic       rfr_ovf
);
    localparam int unsigned CS_W   = 8;
    localparam int unsigned DEBT_W = 3;
    localparam int unsigned CNT_W  = 4;
    localparam logic [DEBT_W-1:0] DEBT_TOP = DEBT_W'(DEBT_MAX);
    localparam logic [DEBT_W-1:0] URG_TH   = DEBT_W'(URG_LVL);

    typedef enum logic [2:0] {IDLE, WAIT, PRE, TRP, REF, TRFC, DONE} state_t;

    state_t            state, state_nxt;
    logic [CS_W-1:0]   msk, msk_nxt;
    logic [CS_W-1:0]   ptr, ptr_nxt;
    logic [CS_W-1:0]   low_bit, cs_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  trp_ld, trfc_ld;
    logic [DEBT_W-1:0] debt_nxt;
    logic              accept, held_off, round_done;

    // ptr is kept one-hot; low_bit isolates the lowest chip select still owed a refresh
    assign low_bit = msk & (~msk + CS_W'(1));
    assign trp_ld  = (trp  == '0) ? CNT_W'(1) : trp;
    assign trfc_ld = (trfc == '0) ? CNT_W'(1) : trfc;

    assign accept     = rfr_req & ~rfr_ack & (debt < DEBT_TOP);
    assign held_off   = rfr_req & ~rfr_ack & (debt == DEBT_TOP);
    assign round_done = (state == DONE);

    // Next-state, round bookkeeping and next values of the registered outputs
    always_comb begin
        state_nxt = state;
        msk_nxt   = msk;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        cs_nxt    = '0;
        debt_nxt  = debt;

        case (state)
            IDLE: if (debt != '0) state_nxt = WAIT;
            WAIT: begin
                if (!mem_busy) begin
                    msk_nxt   = cs_need_rfr;
                    state_nxt = (cs_need_rfr == '0) ? DONE : PRE;
                end
            end
            PRE: begin
                cnt_nxt   = trp_ld;
                state_nxt = TRP;
            end
            TRP: begin
                if (cnt == CNT_W'(1)) begin
                    ptr_nxt   = low_bit;
                    state_nxt = REF;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            REF: begin
                msk_nxt   = msk & ~ptr;
                cnt_nxt   = trfc_ld;
                state_nxt = TRFC;
            end
            TRFC: begin
                if (cnt == CNT_W'(1)) begin
                    if (msk != '0) begin
                        ptr_nxt   = low_bit;
                        state_nxt = REF;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == PRE)      cs_nxt = msk_nxt;
        else if (state_nxt == REF) cs_nxt = ptr_nxt;

        case ({accept, round_done})
            2'b10:   debt_nxt = debt + DEBT_W'(1);
            2'b01:   debt_nxt = debt - DEBT_W'(1);
            default: debt_nxt = debt;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            msk        <= '0;
            ptr        <= '0;
            cnt        <= '0;
            debt       <= '0;
            rfr_ack    <= 1'b0;
            rfr_ovf    <= 1'b0;
            rfr_urgent <= 1'b0;
            rfr_busy   <= 1'b0;
            cmd_pre    <= 1'b0;
            cmd_ref    <= 1'b0;
            cmd_cs     <= '0;
        end else begin
            state      <= state_nxt;
            msk        <= msk_nxt;
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            debt       <= debt_nxt;
            rfr_ack    <= accept;
            rfr_ovf    <= rfr_ovf | held_off;
            rfr_urgent <= (debt >= URG_TH);
            rfr_busy   <= (state_nxt != IDLE);
            cmd_pre    <= (state_nxt == PRE);
            cmd_ref    <= (state_nxt == REF);
            cmd_cs     <= cs_nxt;
        end
    end
endmodule

// File: tb/tb_mc_rfr_sched.sv
// Bench for mc_rfr_sched: a per-cycle timeline model of refresh rounds built from the
// round-length formula, driven by directed scenarios and randomized traffic.
module tb_mc_rfr_sched;
    localparam int DMAX = 7;
    localparam int URG  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rfr_req = 1'b0;
    logic [7:0] cs_need_rfr = 8'h00;
    logic       mem_busy = 1'b0;
    logic [3:0] trp = 4'd0;
    logic [3:0] trfc = 4'd0;
    logic       rfr_ack, rfr_busy, rfr_urgent, cmd_pre, cmd_ref, rfr_ovf;
    logic [7:0] cmd_cs;
    logic [2:0] debt;
    logic [16:0] obs;

    always #5 clk = ~clk;

    mc_rfr_sched #(.DEBT_MAX(DMAX), .URG_LVL(URG)) dut (
        .clk(clk), .rst(rst), .rfr_req(rfr_req), .rfr_ack(rfr_ack),
        .cs_need_rfr(cs_need_rfr), .mem_busy(mem_busy), .trp(trp), .trfc(trfc),
        .rfr_busy(rfr_busy), .rfr_urgent(rfr_urgent), .cmd_pre(cmd_pre),
        .cmd_ref(cmd_ref), .cmd_cs(cmd_cs), .debt(debt), .rfr_ovf(rfr_ovf)
    );

    assign obs = {rfr_ack, rfr_busy, rfr_urgent, cmd_pre, cmd_ref, cmd_cs, debt, rfr_ovf};

    typedef struct packed {
        logic       pre;
        logic       rf;
        logic [7:0] cs;
        logic       done;
    } ev_t;

    int checks = 0;
    int errors = 0;

    // Model: debt arithmetic plus a queue holding the remaining cycles of the current round
    bit  m_ack, m_urg, m_ovf;
    int  m_debt, m_mode;  // mode: 0 not busy, 1 waiting for bus, 2 round running
    ev_t m_cur;
    ev_t rq[$];

    int unsigned pend;
    bit hold;

    function automatic ev_t mk(logic p, logic r, logic [7:0] c, logic d);
        ev_t e;
        e.pre = p; e.rf = r; e.cs = c; e.done = d;
        return e;
    endfunction

    task automatic model_reset();
        m_ack = 0; m_urg = 0; m_ovf = 0; m_debt = 0; m_mode = 0;
        m_cur = '0;
        rq.delete();
    endtask

    task automatic build_round(input logic [7:0] mask, input logic [3:0] tp, input logic [3:0] tf);
        int t;
        int r;
        t = (tp == 4'd0) ? 1 : int'(tp);
        r = (tf == 4'd0) ? 1 : int'(tf);
        rq.delete();
        if (mask != 8'h00) begin
            rq.push_back(mk(1'b1, 1'b0, mask, 1'b0));
            repeat (t) rq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0));
            for (int b = 0; b < 8; b++) begin
                if (mask[b]) begin
                    rq.push_back(mk(1'b0, 1'b1, 8'(1 << b), 1'b0));
                    repeat (r) rq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0));
                end
            end
        end
        rq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1));
    endtask

    task automatic model_step();
        bit acc, ovs, dn;
        acc = rfr_req && !m_ack && (m_debt < DMAX);
        ovs = rfr_req && !m_ack && (m_debt == DMAX);
        dn  = (m_mode == 2) && m_cur.done;
        m_urg = (m_debt >= URG);
        case (m_mode)
            0: if (m_debt != 0) m_mode = 1;
            1: if (!mem_busy) begin
                build_round(cs_need_rfr, trp, trfc);
                m_cur  = rq.pop_front();
                m_mode = 2;
            end
            default: if (m_cur.done) begin
                m_mode = 0;
                m_cur  = '0;
            end else begin
                m_cur = rq.pop_front();
            end
        endcase
        m_debt = m_debt + int'(acc) - int'(dn);
        m_ack  = acc;
        m_ovf  = m_ovf | ovs;
    endtask

    function automatic logic [16:0] exp_vec();
        return {m_ack, (m_mode != 0), m_urg, m_cur.pre, m_cur.rf, m_cur.cs, 3'(m_debt), m_ovf};
    endfunction

    // One clock: advance model, then act as the request generator (hold req until acked)
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (hold) begin
            rfr_req = 1'b0;
            hold = 0;
        end else if (m_ack) begin
            hold = 1;
        end else if (!rfr_req && pend != 0) begin
            rfr_req = 1'b1;
            pend--;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rfr_req = 1'b0; mem_busy = 1'b0; cs_need_rfr = 8'h00;
        pend = 0; hold = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 17'h0) begin errors++; $display("FAIL reset_hold got %h exp %h", obs, 17'h0); end
        rst = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL reset_release got %h exp %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_basic();
        int busy_n = 0, ref_n = 0, pre_n = 0, ack_at = -1, pre_at = -1;
        int ref_at[2];
        logic [7:0] ref_cs[2];
        logic [7:0] pre_cs = 8'h00;
        ref_at[0] = -1; ref_at[1] = -1; ref_cs[0] = 8'h00; ref_cs[1] = 8'h00;
        cs_need_rfr = 8'h05; trp = 4'd2; trfc = 4'd3; mem_busy = 1'b0; pend = 1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL basic_cycle c=%0d got %h exp %h", c, obs, exp_vec()); end
            if (rfr_ack && ack_at < 0) ack_at = c;
            if (rfr_busy) busy_n++;
            if (cmd_pre) begin pre_n++; pre_cs = cmd_cs; pre_at = c; end
            if (cmd_ref) begin
                if (ref_n < 2) begin ref_cs[ref_n] = cmd_cs; ref_at[ref_n] = c; end
                ref_n++;
            end
        end
        checks++;
        if (ack_at != 2) begin errors++; $display("FAIL basic_ack_cycle got %0d exp 2", ack_at); end
        checks++;
        if (busy_n != 13) begin errors++; $display("FAIL basic_busy_len got %0d exp 13", busy_n); end
        checks++;
        if (pre_n != 1 || pre_cs !== 8'h05) begin errors++; $display("FAIL basic_pre got n=%0d cs=%h exp n=1 cs=05", pre_n, pre_cs); end
        checks++;
        if (ref_n != 2 || ref_cs[0] !== 8'h01 || ref_cs[1] !== 8'h04) begin
            errors++; $display("FAIL basic_refs got n=%0d cs=%h,%h exp n=2 cs=01,04", ref_n, ref_cs[0], ref_cs[1]);
        end
        checks++;
        if (ref_at[0] - pre_at != 3 || ref_at[1] - ref_at[0] != 4) begin
            errors++; $display("FAIL basic_gaps got %0d,%0d exp 3,4", ref_at[0] - pre_at, ref_at[1] - ref_at[0]);
        end
        checks++;
        if (debt !== 3'd0) begin errors++; $display("FAIL basic_debt_end got %0d exp 0", debt); end
    endtask

    task automatic test_deferral();
        int strobes = 0, pres = 0;
        bit drained = 0;
        mem_busy = 1'b1; cs_need_rfr = 8'h0F; trp = 4'd1; trfc = 4'd1; pend = 4;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL defer_cycle c=%0d got %h exp %h", c, obs, exp_vec()); end
            if (cmd_pre || cmd_ref) strobes++;
        end
        checks++;
        if (debt !== 3'd4 || rfr_urgent !== 1'b1 || rfr_busy !== 1'b1 || strobes != 0) begin
            errors++; $display("FAIL defer_hold got debt=%0d urg=%b busy=%b strobes=%0d exp 4 1 1 0", debt, rfr_urgent, rfr_busy, strobes);
        end
        mem_busy = 1'b0;
        for (int c = 1; c <= 300 && !drained; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL defer_drain c=%0d got %h exp %h", c, obs, exp_vec()); end
            if (cmd_pre) pres++;
            drained = (m_mode == 0 && m_debt == 0);
        end
        checks++;
        if (!drained || debt !== 3'd0 || pres != 4) begin
            errors++; $display("FAIL defer_drain_end got drained=%0d debt=%0d rounds=%0d exp 1 0 4", drained, debt, pres);
        end
    endtask

    task automatic test_saturation();
        int acks = 0;
        bit drained = 0;
        mem_busy = 1'b1; cs_need_rfr = 8'h01; trp = 4'd0; trfc = 4'd0; pend = 8;
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL sat_cycle c=%0d got %h exp %h", c, obs, exp_vec()); end
        end
        checks++;
        if (debt !== 3'd7 || rfr_ovf !== 1'b1 || rfr_ack !== 1'b0) begin
            errors++; $display("FAIL sat_hold got debt=%0d ovf=%b ack=%b exp 7 1 0", debt, rfr_ovf, rfr_ack);
        end
        mem_busy = 1'b0;
        for (int c = 1; c <= 400 && !drained; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL sat_drain c=%0d got %h exp %h", c, obs, exp_vec()); end
            if (rfr_ack) acks++;
            drained = (m_mode == 0 && m_debt == 0 && pend == 0 && !rfr_req && !hold);
        end
        checks++;
        if (!drained || acks != 1 || debt !== 3'd0 || rfr_ovf !== 1'b1) begin
            errors++; $display("FAIL sat_drain_end got drained=%0d acks=%0d debt=%0d ovf=%b exp 1 1 0 1", drained, acks, debt, rfr_ovf);
        end
    endtask

    task automatic test_simultaneous();
        bit found = 0, drained = 0;
        mem_busy = 1'b0; cs_need_rfr = 8'h02; trp = 4'd1; trfc = 4'd1; pend = 1;
        for (int c = 1; c <= 60 && !found; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL simul_cycle c=%0d got %h exp %h", c, obs, exp_vec()); end
            found = (m_mode == 2) && m_cur.done && !rfr_req && !hold;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL simul_timeout got no DONE cycle exp one within 60");
        end else begin
            rfr_req = 1'b1;
            tick();
            checks++;
            if (debt !== 3'd1 || rfr_ack !== 1'b1 || rfr_busy !== 1'b0) begin
                errors++; $display("FAIL simul_done got debt=%0d ack=%b busy=%b exp 1 1 0", debt, rfr_ack, rfr_busy);
            end
            tick();
            checks++;
            if (rfr_busy !== 1'b1 || obs !== exp_vec()) begin
                errors++; $display("FAIL simul_rewait got %h exp %h", obs, exp_vec());
            end
        end
        for (int c = 1; c <= 100 && !drained; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL simul_drain c=%0d got %h exp %h", c, obs, exp_vec()); end
            drained = (m_mode == 0 && m_debt == 0 && !rfr_req && !hold);
        end
    endtask

    task automatic test_edge();
        int busy_n = 0, ref_n = 0, strobes = 0;
        logic [7:0] pre_cs = 8'h00;
        logic [7:0] ref_cs = 8'h00;
        mem_busy = 1'b0; cs_need_rfr = 8'h80; trp = 4'd0; trfc = 4'd0; pend = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL edge_cycle c=%0d got %h exp %h", c, obs, exp_vec()); end
            if (rfr_busy) busy_n++;
            if (cmd_pre) pre_cs = cmd_cs;
            if (cmd_ref) begin ref_n++; ref_cs = cmd_cs; end
        end
        checks++;
        if (busy_n != 6 || pre_cs !== 8'h80 || ref_cs !== 8'h80 || ref_n != 1) begin
            errors++; $display("FAIL edge_min_wait got busy=%0d pre=%h ref=%h n=%0d exp 6 80 80 1", busy_n, pre_cs, ref_cs, ref_n);
        end
        busy_n = 0;
        cs_need_rfr = 8'h00; pend = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL edge_zero c=%0d got %h exp %h", c, obs, exp_vec()); end
            if (rfr_busy) busy_n++;
            if (cmd_pre || cmd_ref) strobes++;
        end
        checks++;
        if (busy_n != 2 || strobes != 0 || debt !== 3'd0) begin
            errors++; $display("FAIL edge_zero_mask got busy=%0d strobes=%0d debt=%0d exp 2 0 0", busy_n, strobes, debt);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < 200 && m_mode == 2; c++) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin errors++; $display("FAIL rand_settle it=%0d got %h exp %h", it, obs, exp_vec()); end
            end
            trp  = 4'($urandom_range(0, 4));
            trfc = 4'($urandom_range(0, 4));
            for (int c = 0; c < 300; c++) begin
                mem_busy    = ($urandom_range(0, 9) < 3);
                cs_need_rfr = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                if ($urandom_range(0, 5) == 0) pend++;
                tick();
                checks++;
                if (obs !== exp_vec()) begin errors++; $display("FAIL rand_cycle it=%0d c=%0d got %h exp %h", it, c, obs, exp_vec()); end
            end
        end
    endtask

    task automatic test_reset_trfc();
        bit idle = 0, in_trfc = 0, seen_ref = 0;
        pend = 0; mem_busy = 1'b0;
        for (int c = 0; c < 1000 && !idle; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rst_settle got %h exp %h", obs, exp_vec()); end
            idle = (m_mode == 0 && m_debt == 0 && pend == 0 && !rfr_req && !hold);
        end
        cs_need_rfr = 8'h03; trp = 4'd1; trfc = 4'd6; pend = 1;
        for (int c = 0; c < 60 && !in_trfc; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rst_round got %h exp %h", obs, exp_vec()); end
            if (m_cur.rf) seen_ref = 1;
            in_trfc = seen_ref && (m_mode == 2) && !m_cur.rf && !m_cur.pre && !m_cur.done;
        end
        checks++;
        if (!in_trfc || rfr_busy !== 1'b1 || debt !== 3'd1) begin
            errors++; $display("FAIL rst_pre got trfc=%0d busy=%b debt=%0d exp 1 1 1", in_trfc, rfr_busy, debt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 17'h0) begin errors++; $display("FAIL rst_async got %h exp %h", obs, 17'h0); end
        model_reset();
        rfr_req = 1'b0; pend = 0; hold = 0;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 17'h0) begin errors++; $display("FAIL rst_held got %h exp %h", obs, 17'h0); end
        rst = 1'b0;
        repeat (5) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rst_after got %h exp %h", obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_deferral();
        test_saturation();
        test_simultaneous();
        test_edge();
        test_random();
        test_reset_trfc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish before time limit");
        $fatal(1);
    end
endmodule
